// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundle of every signal between the BRAM port arbiter, its two requesters
// (fetch stage, load/store stage), the single-port BRAM and the trap logic.
//
// Signal groups:
//   fetch  : if_req, if_addr -> if_gnt, if_rvalid, if_rdata
//   data   : d_req, d_we, d_addr, d_be, d_wdata -> d_gnt, d_rvalid, d_rdata
//   bram   : mem_en, mem_we, mem_idx, mem_wdata -> mem_rdata (1-cycle latency)
//   trap   : trap_ram, trap_src, trap_addr
//
// Modports:
//   slave  : the arbiter (drives grants, responses, BRAM controls, trap)
//   master : the surroundings (requesters plus BRAM)
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int IDX_W = 10
);
  // Fetch requester
  logic             if_req;
  logic [31:0]      if_addr;
  logic             if_gnt;
  logic             if_rvalid;
  logic [31:0]      if_rdata;
  // Load/store requester
  logic             d_req;
  logic             d_we;
  logic [31:0]      d_addr;
  logic [3:0]       d_be;
  logic [31:0]      d_wdata;
  logic             d_gnt;
  logic             d_rvalid;
  logic [31:0]      d_rdata;
  // BRAM port
  logic             mem_en;
  logic [3:0]       mem_we;
  logic [IDX_W-1:0] mem_idx;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata;
  // RAM trap
  logic             trap_ram;
  logic             trap_src;
  logic [31:0]      trap_addr;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_be, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_idx, mem_wdata, trap_ram, trap_src, trap_addr
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_be, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_idx, mem_wdata, trap_ram, trap_src, trap_addr
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port BRAM between the fetch stage and the load/store stage.
// At most one requester is granted per cycle (data has priority unless fetch
// has been denied STARVE_MAX cycles in a row). The granted access drives the
// BRAM directly; the registered read data is routed back one cycle later to
// the owner of that slot. Misaligned fetches and out-of-range accesses still
// take the slot but never touch the BRAM; they raise trap_ram instead.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : mem_port_arbiter_if.slave (requesters, BRAM port, trap outputs)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int DEPTH      = 1024,
  parameter int IDX_W      = 10,
  parameter int STARVE_MAX = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_port_arbiter_if.slave     bus
);

  localparam logic [3:0]  STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [31:0] ADDR_LIM   = 32'(4 * DEPTH);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_FETCH,
    OWN_DATA
  } owner_e;

  owner_e           resp_owner_q, resp_owner_d;
  logic             resp_fault_q, resp_fault_d;
  logic             resp_store_q, resp_store_d;
  logic [3:0]       starve_q,     starve_d;
  logic             trap_src_q,   trap_src_d;
  logic [31:0]      trap_addr_q,  trap_addr_d;
  logic [IDX_W-1:0] idx_q,        idx_d;
  logic [31:0]      wdata_q,      wdata_d;

  logic if_fault, d_fault;
  logic if_gnt, d_gnt;
  logic mem_en;
  logic [3:0] mem_we;

  // Fault detection and arbitration. Grants are forced low during reset so
  // no access can slip into the BRAM while state is being cleared.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first; a path that leaves one unassigned would infer a latch.
    if_fault = (bus.if_addr[1:0] != 2'b00) || (bus.if_addr >= ADDR_LIM);
    d_fault  = (bus.d_addr >= ADDR_LIM);
    if_gnt   = 1'b0;
    d_gnt    = 1'b0;
    if (!rst) begin
      if (bus.if_req && (!bus.d_req || (starve_q == STARVE_LIM))) begin
        if_gnt = 1'b1;
      end else if (bus.d_req) begin
        d_gnt = 1'b1;
      end
    end
  end

  // Next state for the response slot, trap record, BRAM port and starve count.
  always_comb begin
    resp_owner_d = OWN_NONE;
    resp_fault_d = 1'b0;
    resp_store_d = 1'b0;
    trap_src_d   = trap_src_q;
    trap_addr_d  = trap_addr_q;
    idx_d        = idx_q;
    wdata_d      = wdata_q;
    mem_en       = 1'b0;
    mem_we       = 4'h0;

    // Count consecutive denied fetch cycles; any grant or idle fetch clears it.
    if (bus.if_req && !if_gnt) begin
      starve_d = (starve_q == STARVE_LIM) ? STARVE_LIM : starve_q + 4'd1;
    end else begin
      starve_d = 4'd0;
    end

    if (if_gnt) begin
      resp_owner_d = OWN_FETCH;
      resp_fault_d = if_fault;
      idx_d        = bus.if_addr[IDX_W+1:2];
      wdata_d      = bus.d_wdata;
      mem_en       = !if_fault;
      if (if_fault) begin
        trap_src_d  = 1'b0;
        trap_addr_d = bus.if_addr;
      end
    end else if (d_gnt) begin
      resp_owner_d = OWN_DATA;
      resp_fault_d = d_fault;
      resp_store_d = bus.d_we;
      idx_d        = bus.d_addr[IDX_W+1:2];
      wdata_d      = bus.d_wdata;
      mem_en       = !d_fault;
      mem_we       = (bus.d_we && !d_fault) ? bus.d_be : 4'h0;
      if (d_fault) begin
        trap_src_d  = 1'b1;
        trap_addr_d = bus.d_addr;
      end
    end
  end

  // NOTE: all registers, including the held BRAM index/write data, are cleared
  // by the async reset so nothing observable is X after reset; the BRAM array
  // itself lives outside and is never reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_owner_q <= OWN_NONE;
      resp_fault_q <= 1'b0;
      resp_store_q <= 1'b0;
      starve_q     <= 4'd0;
      trap_src_q   <= 1'b0;
      trap_addr_q  <= 32'h0;
      idx_q        <= '0;
      wdata_q      <= 32'h0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of the others.
      resp_owner_q <= resp_owner_d;
      resp_fault_q <= resp_fault_d;
      resp_store_q <= resp_store_d;
      starve_q     <= starve_d;
      trap_src_q   <= trap_src_d;
      trap_addr_q  <= trap_addr_d;
      idx_q        <= idx_d;
      wdata_q      <= wdata_d;
    end
  end

  // Grants and BRAM controls are combinational; index/write data hold when
  // nothing is granted because *_d defaults to the held value.
  assign bus.if_gnt    = if_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_idx   = idx_d;
  assign bus.mem_wdata = wdata_d;

  // Responses: owner's rvalid one cycle after its grant; read data only for
  // non-faulting loads/fetches, zero otherwise.
  assign bus.if_rvalid = (resp_owner_q == OWN_FETCH);
  assign bus.d_rvalid  = (resp_owner_q == OWN_DATA);
  assign bus.if_rdata  = (bus.if_rvalid && !resp_fault_q) ? bus.mem_rdata : 32'h0;
  assign bus.d_rdata   = (bus.d_rvalid && !resp_fault_q && !resp_store_q) ?
                         bus.mem_rdata : 32'h0;
  assign bus.trap_ram  = resp_fault_q;
  assign bus.trap_src  = trap_src_q;
  assign bus.trap_addr = trap_addr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter. A behavioural BRAM (registered read,
// byte write enables) sits on the memory port. Expected responses are queued
// per requester when a grant is taken and popped in the following cycle.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  mem_port_arbiter_if #(.IDX_W(10)) bus ();

  mem_port_arbiter #(
    .DEPTH(1024),
    .IDX_W(10),
    .STARVE_MAX(3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port BRAM, read-before-write. Two words are preloaded
  // whenever reset is high (arbiter never enables the BRAM during reset).
  logic [31:0] bram [0:1023];
  always @(posedge clk) begin
    if (rst) begin
      bram[4]    <= 32'h00500093;
      bram[1023] <= 32'hCAFEF00D;
    end else if (bus.mem_en) begin
      bus.mem_rdata <= bram[bus.mem_idx];
      for (int b = 0; b < 4; b++) begin
        if (bus.mem_we[b]) bram[bus.mem_idx][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end
    end
  end

  typedef struct {
    logic [31:0] data;
    logic        trap;
    logic [31:0] addr;
  } exp_t;

  exp_t        fq[$];
  exp_t        dq[$];
  logic [31:0] cur_f_data, cur_d_data;
  logic        cur_f_trap, cur_d_trap;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv_f(input logic [31:0] addr, input logic [31:0] data, input logic trap);
    bus.if_req = 1'b1;
    bus.if_addr = addr;
    cur_f_data = data;
    cur_f_trap = trap;
  endtask

  task automatic drv_d(input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wdata, input logic [31:0] data, input logic trap);
    bus.d_req = 1'b1;
    bus.d_we = we;
    bus.d_addr = addr;
    bus.d_be = be;
    bus.d_wdata = wdata;
    cur_d_data = data;
    cur_d_trap = trap;
  endtask

  // Let inputs settle, check grants, queue the expected response per grant.
  task automatic arb(input logic exp_ig, input logic exp_dg);
    #3;
    check("if_gnt", 32'(bus.if_gnt), 32'(exp_ig));
    check("d_gnt", 32'(bus.d_gnt), 32'(exp_dg));
    if (bus.if_gnt) fq.push_back('{cur_f_data, cur_f_trap, bus.if_addr});
    if (bus.d_gnt)  dq.push_back('{cur_d_data, cur_d_trap, bus.d_addr});
  endtask

  task automatic mem(input logic en, input logic [3:0] we, input logic [9:0] idx);
    check("mem_en", 32'(bus.mem_en), 32'(en));
    check("mem_we", 32'(bus.mem_we), 32'(we));
    check("mem_idx", 32'(bus.mem_idx), 32'(idx));
  endtask

  // Advance one clock and compare the response cycle against the queues.
  task automatic tick();
    exp_t        e;
    logic        ev_i, ev_d, exp_trap, exp_src;
    logic [31:0] exp_addr;
    @(posedge clk);
    #1;
    ev_i = (fq.size() != 0);
    ev_d = (dq.size() != 0);
    exp_trap = 1'b0;
    exp_src  = 1'b0;
    exp_addr = 32'h0;
    check("if_rvalid", 32'(bus.if_rvalid), 32'(ev_i));
    check("d_rvalid", 32'(bus.d_rvalid), 32'(ev_d));
    if (ev_i) begin
      e = fq.pop_front();
      check("if_rdata", bus.if_rdata, e.data);
      exp_trap = e.trap;
      exp_addr = e.addr;
    end
    if (ev_d) begin
      e = dq.pop_front();
      check("d_rdata", bus.d_rdata, e.data);
      exp_trap = e.trap;
      exp_src  = 1'b1;
      exp_addr = e.addr;
    end
    check("trap_ram", 32'(bus.trap_ram), 32'(exp_trap));
    if (exp_trap) begin
      check("trap_src", 32'(bus.trap_src), 32'(exp_src));
      check("trap_addr", bus.trap_addr, exp_addr);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    // Reset, with both requests raised to prove grants are suppressed.
    rst = 1'b1;
    bus.if_req = 1'b1; bus.if_addr = 32'h10;
    bus.d_req = 1'b1;  bus.d_we = 1'b1; bus.d_addr = 32'h20;
    bus.d_be = 4'hF;   bus.d_wdata = 32'h0;
    cur_f_data = 32'h0; cur_f_trap = 1'b0;
    cur_d_data = 32'h0; cur_d_trap = 1'b0;
    #1;
    check("rst_if_gnt", 32'(bus.if_gnt), 32'd0);
    check("rst_d_gnt", 32'(bus.d_gnt), 32'd0);
    check("rst_mem_en", 32'(bus.mem_en), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    check("rst_d_rvalid", 32'(bus.d_rvalid), 32'd0);
    check("rst_trap_ram", 32'(bus.trap_ram), 32'd0);
    check("rst_trap_src", 32'(bus.trap_src), 32'd0);
    check("rst_trap_addr", bus.trap_addr, 32'h0);
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Fetch only, held three cycles: granted every cycle, back-to-back responses.
    drv_f(32'h10, 32'h00500093, 1'b0);
    repeat (3) begin arb(1'b1, 1'b0); mem(1'b1, 4'h0, 10'd4); tick(); end
    bus.if_req = 1'b0;
    arb(1'b0, 1'b0); mem(1'b0, 4'h0, 10'd4); tick();

    // Store then load at 0x20.
    drv_d(1'b1, 32'h20, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0);
    arb(1'b0, 1'b1); mem(1'b1, 4'hF, 10'd8);
    check("mem_wdata", bus.mem_wdata, 32'hDEADBEEF); tick();
    drv_d(1'b0, 32'h20, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0);
    arb(1'b0, 1'b1); mem(1'b1, 4'h0, 10'd8); tick();

    // Byte-lane store, zero-enable store, load with ignored low address bits.
    drv_d(1'b1, 32'h40, 4'hF, 32'h11223344, 32'h0, 1'b0);
    arb(1'b0, 1'b1); mem(1'b1, 4'hF, 10'd16); tick();
    drv_d(1'b1, 32'h40, 4'b0010, 32'h0000AA00, 32'h0, 1'b0);
    arb(1'b0, 1'b1); mem(1'b1, 4'b0010, 10'd16); tick();
    drv_d(1'b1, 32'h42, 4'h0, 32'hFFFFFFFF, 32'h0, 1'b0);
    arb(1'b0, 1'b1); mem(1'b1, 4'h0, 10'd16); tick();
    drv_d(1'b0, 32'h43, 4'h0, 32'h0, 32'h1122AA44, 1'b0);
    arb(1'b0, 1'b1); mem(1'b1, 4'h0, 10'd16); tick();
    // Last legal word.
    drv_d(1'b0, 32'hFFF, 4'h0, 32'h0, 32'hCAFEF00D, 1'b0);
    arb(1'b0, 1'b1); mem(1'b1, 4'h0, 10'd1023); tick();
    bus.d_req = 1'b0;

    // Faults: misaligned fetch, out-of-range fetch, data load and store.
    drv_f(32'h6, 32'h0, 1'b1);
    arb(1'b1, 1'b0);
    check("flt_f_mem_en", 32'(bus.mem_en), 32'd0); tick();
    drv_f(32'h1000, 32'h0, 1'b1);
    arb(1'b1, 1'b0);
    check("flt_f2_mem_en", 32'(bus.mem_en), 32'd0); tick();
    bus.if_req = 1'b0;
    drv_d(1'b0, 32'h1000, 4'h0, 32'h0, 32'h0, 1'b1);
    arb(1'b0, 1'b1);
    check("flt_d_mem_en", 32'(bus.mem_en), 32'd0); tick();
    drv_d(1'b1, 32'h1FFC, 4'hF, 32'h12345678, 32'h0, 1'b1);
    arb(1'b0, 1'b1);
    check("flt_st_mem_en", 32'(bus.mem_en), 32'd0);
    check("flt_st_mem_we", 32'(bus.mem_we), 32'd0); tick();
    // Good load afterwards: no trap, trap record held.
    drv_d(1'b0, 32'h20, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0);
    arb(1'b0, 1'b1); tick();
    check("hold_trap_src", 32'(bus.trap_src), 32'd1);
    check("hold_trap_addr", bus.trap_addr, 32'h1FFC);

    // Contention: data wins until fetch has waited STARVE_MAX cycles.
    drv_f(32'h10, 32'h00500093, 1'b0);
    drv_d(1'b0, 32'h20, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0);
    for (int i = 0; i < 8; i++) begin
      check("starve_cnt", 32'(dut.starve_q), 32'(i % 4));
      arb((i % 4) == 3, (i % 4) != 3);
      tick();
    end
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    arb(1'b0, 1'b0); tick();

    // Reset in the response cycle of a load, with starve_cnt built up to 2.
    drv_f(32'h10, 32'h00500093, 1'b0);
    drv_d(1'b0, 32'h20, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0);
    arb(1'b0, 1'b1); tick();
    arb(1'b0, 1'b1); tick();
    check("pre_rst_starve", 32'(dut.starve_q), 32'd2);
    bus.d_req = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_d_rvalid", 32'(bus.d_rvalid), 32'd0);
    check("mid_rst_starve", 32'(dut.starve_q), 32'd0);
    check("mid_rst_if_gnt", 32'(bus.if_gnt), 32'd0);
    @(posedge clk); #1;
    check("rst_hold_d_rvalid", 32'(bus.d_rvalid), 32'd0);
    rst = 1'b0;
    arb(1'b1, 1'b0); mem(1'b1, 4'h0, 10'd4); tick();
    bus.if_req = 1'b0;
    arb(1'b0, 1'b0); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
